// File: rtl/plru_replace_ctrl_if.sv
// Cache-side and memory-side signals of the PLRU miss/replacement controller.
// master = controller, slave = cache datapath + physical memory.
interface plru_replace_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int WAY_W  = 4,
  parameter int CNT_W  = 16
);
  logic              hit_update;
  logic [WAY_W-1:0]  hit_way;
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic [WAY_W-1:0]  plru_victim;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_tag_addr;
  logic              pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [WAY_W-1:0]  wb_data_sel;
  logic              alloc_we;
  logic [WAY_W-1:0]  alloc_way;
  logic              lru_load;
  logic [WAY_W-1:0]  lru_way;
  logic              miss_done;
  logic              busy;
  logic [CNT_W-1:0]  miss_count;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    input  hit_update, hit_way, miss_req, miss_addr, plru_victim, victim_dirty,
           victim_tag_addr, pmem_resp,
    output pmem_read, pmem_write, pmem_addr, wb_data_sel, alloc_we, alloc_way,
           lru_load, lru_way, miss_done, busy, miss_count, wb_count
  );

  modport slave (
    output hit_update, hit_way, miss_req, miss_addr, plru_victim, victim_dirty,
           victim_tag_addr, pmem_resp,
    input  pmem_read, pmem_write, pmem_addr, wb_data_sel, alloc_we, alloc_way,
           lru_load, lru_way, miss_done, busy, miss_count, wb_count
  );
endinterface

// File: rtl/plru_replace_ctrl.sv
// Miss sequencer for a 16-way PLRU cache: write-back, refill, allocate, done.
// Shares the PLRU update port between hits (IDLE) and allocation (ALLOC).
module plru_replace_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int OFFSET_W = 4,
   parameter int WAY_W    = 4,
   parameter int CNT_W    = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   plru_replace_ctrl_if.master bus
);

   typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, ALLOC, DONE} state_t;

   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

   state_t            state;
   logic [WAY_W-1:0]  v_way;
   logic [ADDR_W-1:0] m_line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         v_way           <= '0;
         m_line          <= '0;
         bus.pmem_read   <= 1'b0;
         bus.pmem_write  <= 1'b0;
         bus.pmem_addr   <= '0;
         bus.wb_data_sel <= '0;
         bus.alloc_we    <= 1'b0;
         bus.alloc_way   <= '0;
         bus.miss_done   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.miss_count  <= '0;
         bus.wb_count    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.miss_req) begin
               // Only sampling point of the victim; later PLRU moves don't matter.
               v_way    <= bus.plru_victim;
               m_line   <= bus.miss_addr & LINE_MASK;
               bus.busy <= 1'b1;
               if (bus.miss_count != '1) bus.miss_count <= bus.miss_count + CNT_W'(1);
               if (bus.victim_dirty) begin
                  state           <= WRITEBACK;
                  bus.pmem_write  <= 1'b1;
                  bus.pmem_addr   <= bus.victim_tag_addr & LINE_MASK;
                  bus.wb_data_sel <= bus.plru_victim;
               end else begin
                  state         <= REFILL;
                  bus.pmem_read <= 1'b1;
                  bus.pmem_addr <= bus.miss_addr & LINE_MASK;
               end
            end
            WRITEBACK: if (bus.pmem_resp) begin
               state           <= REFILL;
               bus.pmem_write  <= 1'b0;
               bus.pmem_read   <= 1'b1;
               bus.pmem_addr   <= m_line;
               bus.wb_data_sel <= '0;
               if (bus.wb_count != '1) bus.wb_count <= bus.wb_count + CNT_W'(1);
            end
            REFILL: if (bus.pmem_resp) begin
               state         <= ALLOC;
               bus.pmem_read <= 1'b0;
               bus.pmem_addr <= '0;
               bus.alloc_we  <= 1'b1;
               bus.alloc_way <= v_way;
            end
            ALLOC: begin
               state         <= DONE;
               bus.alloc_we  <= 1'b0;
               bus.alloc_way <= '0;
               bus.miss_done <= 1'b1;
            end
            DONE: begin
               state         <= IDLE;
               bus.miss_done <= 1'b0;
               bus.busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Hits outside IDLE are a protocol error for a blocking cache and are dropped.
   always_comb begin
      bus.lru_load = 1'b0;
      bus.lru_way  = '0;
      if (state == ALLOC) begin
         bus.lru_load = 1'b1;
         bus.lru_way  = v_way;
      end else if (state == IDLE && bus.hit_update) begin
         bus.lru_load = 1'b1;
         bus.lru_way  = bus.hit_way;
      end
   end

endmodule

// File: tb/tb_plru_replace_ctrl.sv
// Scoreboard bench: directed misses push expected memory/alloc/done events,
// a negedge monitor pops and compares them as the controller produces them.
`timescale 1ns/1ps
module tb_plru_replace_ctrl;

   localparam int K_MEM = 0, K_ALLOC = 1, K_DONE = 2;

   typedef struct {
      int          kind;
      logic        w;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   plru_replace_ctrl_if #(.ADDR_W(16), .WAY_W(4), .CNT_W(16)) bif ();
   plru_replace_ctrl_if #(.ADDR_W(16), .WAY_W(4), .CNT_W(2))  sif ();

   plru_replace_ctrl #(.ADDR_W(16), .OFFSET_W(4), .WAY_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bif));
   plru_replace_ctrl #(.ADDR_W(16), .OFFSET_W(4), .WAY_W(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(sif));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic w, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.kind = kind; e.w = w; e.a = a; e.b = b;
      q.push_back(e);
   endtask

   // Monitor: pops one expected event per observed DUT event.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bif.pmem_resp && (bif.pmem_read || bif.pmem_write)) begin
            if (q.size() == 0) chk("mem_unexpected", 1, 0);
            else begin
               e = q.pop_front();
               chk("mem_kind", e.kind, K_MEM);
               chk("mem_write", bif.pmem_write, e.w);
               chk("mem_read", bif.pmem_read, !e.w);
               chk("mem_addr", bif.pmem_addr, e.a);
               if (e.w) chk("wb_data_sel", bif.wb_data_sel, e.b);
            end
         end
         if (bif.alloc_we) begin
            if (q.size() == 0) chk("alloc_unexpected", 1, 0);
            else begin
               e = q.pop_front();
               chk("alloc_kind", e.kind, K_ALLOC);
               chk("alloc_way", bif.alloc_way, e.a);
               chk("alloc_lru_load", bif.lru_load, 1);
               chk("alloc_lru_way", bif.lru_way, e.a);
            end
         end
         if (bif.miss_done) begin
            if (q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = q.pop_front();
               chk("done_kind", e.kind, K_DONE);
               chk("miss_count", bif.miss_count, e.a);
               chk("wb_count", bif.wb_count, e.b);
            end
         end
      end
   end

   task automatic respond(input int n, input bit hit_chk);
      for (int i = 0; i < n; i++) begin
         if (hit_chk && i == 0) begin
            bif.hit_update = 1'b1; bif.hit_way = 4'd6;
            @(negedge clk);
            chk("hit_in_refill_load", bif.lru_load, 0);
            chk("hit_in_refill_way", bif.lru_way, 0);
         end
         @(posedge clk); #1;
         bif.hit_update = 1'b0;
      end
      bif.pmem_resp = 1'b1;
      @(posedge clk); #1;
      bif.pmem_resp = 1'b0;
   endtask

   // Called right after posedge+1; returns at posedge+1 with the controller in IDLE.
   task automatic run_miss(input logic [15:0] addr, input logic [3:0] vic, input logic dirty,
                           input logic [15:0] tag, input int wb_wait, input int rf_wait,
                           input int sim_hit, input bit hit_chk,
                           input logic [15:0] emc, input logic [15:0] ewc);
      bit seen;
      if (dirty) push(K_MEM, 1'b1, tag, {12'h0, vic});
      push(K_MEM, 1'b0, addr & 16'hFFF0, 16'h0);
      push(K_ALLOC, 1'b0, {12'h0, vic}, 16'h0);
      push(K_DONE, 1'b0, emc, ewc);
      bif.miss_req = 1'b1; bif.miss_addr = addr; bif.plru_victim = vic;
      bif.victim_dirty = dirty; bif.victim_tag_addr = tag;
      if (sim_hit >= 0) begin
         bif.hit_update = 1'b1; bif.hit_way = 4'(sim_hit);
         @(negedge clk);
         chk("sim_hit_load", bif.lru_load, 1);
         chk("sim_hit_way", bif.lru_way, sim_hit);
      end
      @(posedge clk); #1;
      bif.hit_update = 1'b0;
      bif.plru_victim = ~vic; bif.victim_dirty = ~dirty;
      bif.victim_tag_addr = 16'hDEAD; bif.miss_addr = 16'hBEEF;
      chk("busy_inflight", bif.busy, 1);
      if (dirty) respond(wb_wait, 1'b0);
      respond(rf_wait, hit_chk);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bif.miss_done) seen = 1;
      end
      chk("done_timeout", seen, 1);
      bif.miss_req = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_done", bif.busy, 0);
   endtask

   initial begin
      bif.hit_update = 0; bif.hit_way = 0; bif.miss_req = 0; bif.miss_addr = 0;
      bif.plru_victim = 0; bif.victim_dirty = 0; bif.victim_tag_addr = 0; bif.pmem_resp = 0;
      sif.hit_update = 0; sif.hit_way = 0; sif.miss_req = 0; sif.miss_addr = 16'h0100;
      sif.plru_victim = 4'd2; sif.victim_dirty = 0; sif.victim_tag_addr = 16'h0200; sif.pmem_resp = 0;

      #23;
      chk("rst_busy", bif.busy, 0);
      chk("rst_pmem", {bif.pmem_read, bif.pmem_write}, 0);
      chk("rst_addr", bif.pmem_addr, 0);
      chk("rst_outs", {bif.alloc_we, bif.miss_done, bif.lru_load}, 0);
      chk("rst_counts", {bif.miss_count, bif.wb_count}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Hit in IDLE touches the PLRU combinationally
      bif.hit_update = 1'b1; bif.hit_way = 4'd9;
      @(negedge clk);
      chk("idle_hit_load", bif.lru_load, 1);
      chk("idle_hit_way", bif.lru_way, 9);
      @(posedge clk); #1;
      bif.hit_update = 1'b0;
      @(negedge clk);
      chk("no_hit_load", bif.lru_load, 0);
      chk("hit_no_miss", bif.miss_count, 0);
      @(posedge clk); #1;

      run_miss(16'h12A7, 4'd5,  1'b0, 16'h7770, 0, 4, -1, 1'b1, 16'd1, 16'd0);
      run_miss(16'h8E5B, 4'd11, 1'b1, 16'h4C30, 2, 3, -1, 1'b0, 16'd2, 16'd1);
      run_miss(16'h0345, 4'd7,  1'b0, 16'h1230, 0, 1,  3, 1'b0, 16'd3, 16'd1);

      // Reset in the middle of a write-back
      bif.miss_req = 1'b1; bif.miss_addr = 16'h1111; bif.plru_victim = 4'd11;
      bif.victim_dirty = 1'b1; bif.victim_tag_addr = 16'h4C30;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wb_active", bif.pmem_write, 1);
      chk("wb_count_mid", bif.miss_count, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pmem_write", bif.pmem_write, 0);
      chk("async_rst_busy", bif.busy, 0);
      chk("async_rst_counts", {bif.miss_count, bif.wb_count}, 0);
      bif.miss_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_idle", bif.busy, 0);

      // Saturation on a 2-bit counter instance, pmem always responding
      sif.victim_dirty = 1'b1; sif.pmem_resp = 1'b1; sif.miss_req = 1'b1;
      @(posedge clk); #1;
      chk("sat_first_miss", sif.miss_count, 1);
      repeat (39) @(posedge clk);
      #1;
      sif.miss_req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("sat_miss_count", sif.miss_count, 3);
      chk("sat_wb_count", sif.wb_count, 3);
      chk("sat_idle", sif.busy, 0);

      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
